dbus_ic: RTL and testbench
==========================

# dbus_ic

Parametrised data-bus interconnect replacing the fixed four-bank decoder: one master port fans out to `NS` slave banks selected by the top `BSW` address bits. Unlike the fixed decoder, it uses a request/acknowledge handshake so slaves can insert wait states. Unmapped banks return an error response, and an optional watchdog aborts transfers that a slave never acknowledges. It sits between the core's load/store unit and the RAM, IO, timer and interrupt-controller slaves.

## Interface
- `DW`, 16: data width.
- `AW`, 16: master address width.
- `BSW`, 4: bank-select width, taken from `m_addr[AW-1:AW-BSW]`.
- `NS`, 4: number of mapped slaves, 1..2^BSW. Banks `0..NS-1` are mapped; the rest are unmapped.
- `TO_W`, 8: watchdog counter width.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `m_req`, in, 1: master request. Held until `m_rdy`.
- `m_we`, in, 1: 1 = write, 0 = read.
- `m_addr`, in, AW: byte-free word address.
- `m_din`, in, DW: write data.
- `m_rdy`, out, 1: one-cycle completion pulse.
- `m_dout`, out, DW: read data. Valid in the `m_rdy` cycle and held until the next completion.
- `m_err`, out, 1: error qualifier. Valid with `m_rdy`.
- `err_addr`, out, AW: address of the most recent errored transfer.
- `s_req`, out, NS: one-hot slave request.
- `s_we`, out, 1: write enable, broadcast to all slaves.
- `s_addr`, out, AW-BSW: in-bank address, broadcast.
- `s_din`, out, DW: write data, broadcast.
- `s_dout`, in, NS*DW: read data. Slave k drives bits `[k*DW +: DW]`.
- `s_ack`, in, NS: slave acknowledge, one bit per slave.

## Operation
- **State machine states:** IDLE, BUSY, RESP.
- **IDLE:**
  - With `m_req`=1, register `m_we`, `m_addr` and `m_din` into `s_we`, `s_addr`, `s_din` and a bank register.
  - Mapped bank → set `s_req[bank]` and go to BUSY.
  - Unmapped bank → set `m_err`, load `err_addr`, go to RESP.
- **BUSY:**
  - `s_req` is held until `s_ack[bank]`=1.
  - On ack, capture the selected `s_dout` slice (reads only; writes leave `m_dout` unchanged), clear `s_req`, go to RESP.
- **RESP:** `m_rdy`=1 for exactly one cycle, then go to IDLE.
- **Ignored acks:** acks from non-selected slaves, and any ack seen in IDLE or RESP, are ignored.
- **Broadcast signals:** `s_we`, `s_addr` and `s_din` stay stable from the cycle `s_req` rises until it falls. Only the selected `s_req` bit may be 1.
- **`m_err`:** cleared whenever a transaction completes without error.
- **`err_addr`:** keeps its value until the next error.

## Timing
- **Reset values:** `m_rdy`=0, `m_err`=0, `m_dout`=0, `err_addr`=0, `s_req`=0, `s_we`=0, `s_addr`=0, `s_din`=0, state IDLE, watchdog counter 0.
- **Zero-wait slave** (ack in the first BUSY cycle): request accepted in cycle 0, `s_req` high in cycle 1, `m_rdy` in cycle 2.
- **Wait states:** a slave acking after W extra cycles gives `m_rdy` in cycle 2+W.
- **Unmapped bank:** `m_rdy` and `m_err` in cycle 1.
- **Back-to-back transfers:** the next request can be accepted in the cycle after `m_rdy`. Minimum period is 3 cycles for mapped banks and 2 for unmapped banks.
- **Reset mid-transfer:** in the next cycle return to IDLE with all outputs at reset values. `s_req` drops without an ack, and slaves must tolerate this.
- **Simultaneous ack and watchdog expiry:** the ack wins and the transfer completes normally.

## Configuration
- **Macro:** `DBUS_IC_TIMEOUT_EN`.
- **Defined:**
  - A `TO_W`-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches 2^TO_W-1 with no ack: drop `s_req`, set `m_err`, load `err_addr`, leave `m_dout` unchanged, go to RESP.
  - Timeout latency is therefore 2^TO_W cycles after `s_req` rises.
- **Undefined:** BUSY waits indefinitely for an ack and no counter logic is generated.

## Structure
- **Package `dbus_pkg`:** holds the state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and the default `DW`, `AW` and `BSW` constants shared with the slaves.
- **Sub-module `dbus_ic_wdog`:** the watchdog counter, with a clear, an enable and an expiry pulse. It is instantiated only under `DBUS_IC_TIMEOUT_EN`.
- **Inline logic:** the bank decode and read-data mux stay in `dbus_ic`.

## Test plan
- **Zero-wait read:** read addr 16'h1004 from slave 1, which acks in its first cycle with 16'hA5A5 → `s_req`=4'b0010 for 1 cycle, `s_addr`=12'h004, `m_rdy` 2 cycles after the request, `m_dout`=16'hA5A5, `m_err`=0.
- **Wait-state write:** write 16'h1234 to addr 16'h0010 with slave 0 acking after 5 wait cycles → `s_we`, `s_addr` and `s_din` stable throughout, `m_rdy` in cycle 7, `m_dout` unchanged.
- **Unmapped bank:** access addr 16'h7ABC with NS=4 → no `s_req`, `m_rdy` and `m_err` in cycle 1, `err_addr`=16'h7ABC. A following good access clears `m_err`.
- **Timeout** (macro defined, TO_W=4): slave 2 never acks → `s_req` drops and `m_rdy` with `m_err` arrive 16 cycles after `s_req` rose. A stray `s_ack[3]` driven during the wait is ignored.
- **Reset mid-transfer:** assert `rst` in the third BUSY cycle → next cycle `s_req`=0, `m_rdy`=0, `m_dout`=0, state IDLE. A new request then completes normally.
- **Back-to-back accesses:** three consecutive zero-wait reads to slaves 0, 3, 0 → `m_rdy` every 3 cycles with correct per-slave data.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared data-bus definitions: FSM state encoding and default bus geometry
// used by the interconnect and its slaves.
package dbus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dbus_state_e;

   localparam int DBUS_DW  = 16;
   localparam int DBUS_AW  = 16;
   localparam int DBUS_BSW = 4;

endpackage

// File: rtl/dbus_ic_wdog.sv
// Transfer watchdog: counts stalled BUSY cycles and pulses exp_o on the
// cycle the counter sits at its all-ones value while still enabled.
module dbus_ic_wdog #(
   parameter int TO_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic exp_o
);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   // Clear dominates so every new transfer starts counting from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign exp_o = en_i && (cnt_q == '1);

endmodule

// File: rtl/dbus_ic.sv
// Request/acknowledge data-bus interconnect: one master fanned out to NS banks
// selected by the top BSW address bits. Optional watchdog: DBUS_IC_TIMEOUT_EN.
module dbus_ic
   import dbus_pkg::*;
#(
   parameter int DW   = DBUS_DW,
   parameter int AW   = DBUS_AW,
   parameter int BSW  = DBUS_BSW,
   parameter int NS   = 4,
   parameter int TO_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               m_req,
   input  logic               m_we,
   input  logic [AW-1:0]      m_addr,
   input  logic [DW-1:0]      m_din,
   output logic               m_rdy,
   output logic [DW-1:0]      m_dout,
   output logic               m_err,
   output logic [AW-1:0]      err_addr,
   output logic [NS-1:0]      s_req,
   output logic               s_we,
   output logic [AW-BSW-1:0]  s_addr,
   output logic [DW-1:0]      s_din,
   input  logic [NS*DW-1:0]   s_dout,
   input  logic [NS-1:0]      s_ack
);

   if (NS < 1 || NS > (1 << BSW) || BSW >= AW || TO_W < 1) begin : gBadParams
      $error("dbus_ic: illegal parameter combination");
   end

   dbus_state_e       state_q, state_d;
   logic [NS-1:0]     sReq_q, sReq_d;
   logic              sWe_q, sWe_d;
   logic [AW-BSW-1:0] sAddr_q, sAddr_d;
   logic [DW-1:0]     sDin_q, sDin_d;
   logic [BSW-1:0]    bank_q, bank_d;
   logic [DW-1:0]     mDout_q, mDout_d;
   logic              mErr_q, mErr_d;
   logic [AW-1:0]     errAddr_q, errAddr_d;

   logic [BSW-1:0]    reqBank;
   logic              reqMapped;
   logic              ackSel;
   logic              wdogExp;

   assign reqBank   = m_addr[AW-1 -: BSW];
   assign reqMapped = int'(reqBank) < NS;
   // sReq_q is one-hot on the selected bank, so this masks off foreign acks.
   assign ackSel    = |(s_ack & sReq_q);

`ifdef DBUS_IC_TIMEOUT_EN
   dbus_ic_wdog #(
      .TO_W (TO_W)
   ) uWdog (
      .clk   (clk),
      .rst   (rst),
      .clr_i (state_q != BUSY),
      .en_i  ((state_q == BUSY) && !ackSel),
      .exp_o (wdogExp)
   );
`else
   assign wdogExp = 1'b0;
`endif

   // Next-state and registered-output logic; an ack always beats expiry.
   always_comb begin
      state_d   = state_q;
      sReq_d    = sReq_q;
      sWe_d     = sWe_q;
      sAddr_d   = sAddr_q;
      sDin_d    = sDin_q;
      bank_d    = bank_q;
      mDout_d   = mDout_q;
      mErr_d    = mErr_q;
      errAddr_d = errAddr_q;
      unique case (state_q)
         IDLE: begin
            if (m_req) begin
               sWe_d   = m_we;
               sAddr_d = m_addr[AW-BSW-1:0];
               sDin_d  = m_din;
               bank_d  = reqBank;
               if (reqMapped) begin
                  for (int k = 0; k < NS; k++) begin
                     sReq_d[k] = (int'(reqBank) == k);
                  end
                  state_d = BUSY;
               end else begin
                  mErr_d    = 1'b1;
                  errAddr_d = m_addr;
                  state_d   = RESP;
               end
            end
         end
         BUSY: begin
            if (ackSel) begin
               if (!sWe_q) begin
                  for (int k = 0; k < NS; k++) begin
                     if (int'(bank_q) == k) begin
                        mDout_d = s_dout[k*DW +: DW];
                     end
                  end
               end
               mErr_d  = 1'b0;
               sReq_d  = '0;
               state_d = RESP;
            end else if (wdogExp) begin
               mErr_d    = 1'b1;
               errAddr_d = {bank_q, sAddr_q};
               sReq_d    = '0;
               state_d   = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            sReq_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sReq_q    <= '0;
         sWe_q     <= 1'b0;
         sAddr_q   <= '0;
         sDin_q    <= '0;
         bank_q    <= '0;
         mDout_q   <= '0;
         mErr_q    <= 1'b0;
         errAddr_q <= '0;
      end else begin
         state_q   <= state_d;
         sReq_q    <= sReq_d;
         sWe_q     <= sWe_d;
         sAddr_q   <= sAddr_d;
         sDin_q    <= sDin_d;
         bank_q    <= bank_d;
         mDout_q   <= mDout_d;
         mErr_q    <= mErr_d;
         errAddr_q <= errAddr_d;
      end
   end

   assign m_rdy    = (state_q == RESP);
   assign m_dout   = mDout_q;
   assign m_err    = mErr_q;
   assign err_addr = errAddr_q;
   assign s_req    = sReq_q;
   assign s_we     = sWe_q;
   assign s_addr   = sAddr_q;
   assign s_din    = sDin_q;

endmodule

// File: tb/tb_dbus_ic.sv
// Self-checking bench for dbus_ic: directed cases plus randomized transfers
// against a transaction-level model of the bus protocol.
module tb_dbus_ic;

   localparam int DW   = 16;
   localparam int AW   = 16;
   localparam int BSW  = 4;
   localparam int NS   = 4;
   localparam int TO_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              m_req;
   logic              m_we;
   logic [AW-1:0]     m_addr;
   logic [DW-1:0]     m_din;
   logic              m_rdy;
   logic [DW-1:0]     m_dout;
   logic              m_err;
   logic [AW-1:0]     err_addr;
   logic [NS-1:0]     s_req;
   logic              s_we;
   logic [AW-BSW-1:0] s_addr;
   logic [DW-1:0]     s_din;
   logic [NS*DW-1:0]  s_dout;
   logic [NS-1:0]     s_ack;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   logic [DW-1:0] expDout;
   logic          expErr;
   logic [AW-1:0] expErrAddr;

   dbus_ic #(
      .DW   (DW),
      .AW   (AW),
      .BSW  (BSW),
      .NS   (NS),
      .TO_W (TO_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m_req    (m_req),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_din    (m_din),
      .m_rdy    (m_rdy),
      .m_dout   (m_dout),
      .m_err    (m_err),
      .err_addr (err_addr),
      .s_req    (s_req),
      .s_we     (s_we),
      .s_addr   (s_addr),
      .s_din    (s_din),
      .s_dout   (s_dout),
      .s_ack    (s_ack)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One master transfer, with the slave acking waitCyc cycles late.
   // Starts on the next negedge (DUT must be idle there); returns at the
   // negedge of the m_rdy cycle with rdyCycle set to that cycle number.
   task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] din, input logic [DW-1:0] rdata,
                                input int waitCyc, output int rdyCycle);
      int            bank;
      bit            mapped;
      bit            toErr;
      int            expLat;
      logic [NS-1:0] sel;
      bank   = int'(addr[AW-1 -: BSW]);
      mapped = bank < NS;
      toErr  = 1'b0;
`ifdef DBUS_IC_TIMEOUT_EN
      if (mapped && waitCyc >= (1 << TO_W)) toErr = 1'b1;
`endif
      if (!mapped)    expLat = 1;
      else if (toErr) expLat = (1 << TO_W) + 1;
      else            expLat = 2 + waitCyc;
      sel = '0;
      if (mapped) sel[bank] = 1'b1;
      rdyCycle = -1;

      @(negedge clk);
      m_req  = 1'b1;
      m_we   = we;
      m_addr = addr;
      m_din  = din;
      s_ack  = NS'($urandom);
      s_dout = {$urandom, $urandom};
      for (int n = 1; n <= expLat; n++) begin
         @(negedge clk);
         checkOutput("m_rdy", 32'(m_rdy), 32'(n == expLat));
         if (mapped && n < expLat) begin
            checkOutput("s_req", 32'(s_req), 32'(sel));
            checkOutput("s_we", 32'(s_we), 32'(we));
            checkOutput("s_addr", 32'(s_addr), 32'(addr[AW-BSW-1:0]));
            checkOutput("s_din", 32'(s_din), 32'(din));
         end else begin
            checkOutput("s_req_idle", 32'(s_req), 32'd0);
         end
         if (n == expLat) begin
            if (!mapped || toErr) begin
               expErr     = 1'b1;
               expErrAddr = addr;
            end else begin
               expErr = 1'b0;
               if (!we) expDout = rdata;
            end
            checkOutput("m_err", 32'(m_err), 32'(expErr));
            checkOutput("m_dout", 32'(m_dout), 32'(expDout));
            checkOutput("err_addr", 32'(err_addr), 32'(expErrAddr));
            rdyCycle = cycle;
            m_req    = 1'b0;
            s_ack    = NS'($urandom);
            s_dout   = {$urandom, $urandom};
         end else if (mapped && n == 1 + waitCyc) begin
            s_ack  = NS'($urandom) | sel;
            s_dout = {$urandom, $urandom};
            s_dout[bank*DW +: DW] = rdata;
         end else begin
            s_ack  = NS'($urandom) & ~sel;
            s_dout = {$urandom, $urandom};
         end
      end
   endtask

   initial begin
      int t0, t1, t2;
      rst        = 1'b1;
      m_req      = 1'b0;
      m_we       = 1'b0;
      m_addr     = '0;
      m_din      = '0;
      s_ack      = '0;
      s_dout     = '0;
      expDout    = '0;
      expErr     = 1'b0;
      expErrAddr = '0;

      repeat (3) @(negedge clk);
      checkOutput("rst_m_rdy", 32'(m_rdy), 32'd0);
      checkOutput("rst_m_err", 32'(m_err), 32'd0);
      checkOutput("rst_m_dout", 32'(m_dout), 32'd0);
      checkOutput("rst_err_addr", 32'(err_addr), 32'd0);
      checkOutput("rst_s_req", 32'(s_req), 32'd0);
      checkOutput("rst_s_we", 32'(s_we), 32'd0);
      checkOutput("rst_s_addr", 32'(s_addr), 32'd0);
      checkOutput("rst_s_din", 32'(s_din), 32'd0);
      rst = 1'b0;

      applyStimulus(1'b0, 16'h1004, 16'h0000, 16'hA5A5, 0, t0);
      applyStimulus(1'b1, 16'h0010, 16'h1234, 16'hFFFF, 5, t0);
      applyStimulus(1'b0, 16'h7ABC, 16'h0000, 16'h0000, 0, t0);
      applyStimulus(1'b0, 16'h2000, 16'h0000, 16'h5A5A, 1, t0);

      applyStimulus(1'b0, 16'h0100, 16'h0000, 16'h1111, 0, t0);
      applyStimulus(1'b0, 16'h3200, 16'h0000, 16'h3333, 0, t1);
      applyStimulus(1'b0, 16'h0300, 16'h0000, 16'h0C0C, 0, t2);
      checkOutput("b2b_period_1", 32'(t1 - t0), 32'd3);
      checkOutput("b2b_period_2", 32'(t2 - t1), 32'd3);

      applyStimulus(1'b1, 16'h9000, 16'hBEEF, 16'h0000, 0, t0);
      applyStimulus(1'b0, 16'hF001, 16'h0000, 16'h0000, 0, t1);
      checkOutput("unmapped_period", 32'(t1 - t0), 32'd2);

      // Reset lands in the third BUSY cycle of a never-acked read.
      @(negedge clk);
      m_req  = 1'b1;
      m_we   = 1'b0;
      m_addr = 16'h1111;
      s_ack  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_s_req", 32'(s_req), 32'd0);
      checkOutput("mid_rst_m_rdy", 32'(m_rdy), 32'd0);
      checkOutput("mid_rst_m_dout", 32'(m_dout), 32'd0);
      checkOutput("mid_rst_m_err", 32'(m_err), 32'd0);
      checkOutput("mid_rst_err_addr", 32'(err_addr), 32'd0);
      rst        = 1'b0;
      m_req      = 1'b0;
      expDout    = '0;
      expErr     = 1'b0;
      expErrAddr = '0;
      applyStimulus(1'b0, 16'h1002, 16'h0000, 16'h4242, 2, t0);

`ifdef DBUS_IC_TIMEOUT_EN
      applyStimulus(1'b0, 16'h2040, 16'h0000, 16'h7777, 1000, t0);
      applyStimulus(1'b0, 16'h2042, 16'h0000, 16'h6666, (1 << TO_W) - 1, t0);
      applyStimulus(1'b1, 16'h3044, 16'hCAFE, 16'h0000, 1000, t0);
      applyStimulus(1'b0, 16'h0046, 16'h0000, 16'h2468, 0, t0);
`endif

      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                       int'($urandom_range(0, 4)), t0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
